alu_muldiv: RTL

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv_pkg.sv | 43 ++++
 rtl/div_iter.sv | 93 +++++++++
 rtl/alu_muldiv.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_pkg.sv
// -----------------------------------------------------------------------------
// alu_muldiv_pkg
// Shared definitions for the ALU and its multiply/divide unit: the main ALU
// operation codes, the multiply/divide operation codes carried on md_op and
// the state encoding of the multiply/divide sequencer.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_muldiv_pkg;

    // Main ALU operation codes.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } alu_op_e;

    // Multiply/divide unit operation codes (md_op).
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // Multiply/divide sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Iterative restoring divider working on operand magnitudes, one quotient bit
// per clock. The first bit is produced on the loading edge, so valid rises
// WIDTH-1 cycles after start and the result holds until the next start.
// Signs are applied to the outputs combinationally.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               load operands and begin (ignored while kill is high)
//   kill                abandon the division in progress
//   is_signed           operands are two's complement
//   dividend, divisor   operands, sampled on start (divisor must be non-zero)
//   quotient, remainder signed/unsigned result, meaningful while valid
//   valid               result ready
// -----------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             kill,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q, q_neg_q, r_neg_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        a_neg = is_signed && dividend[WIDTH-1];
        b_neg = is_signed && divisor[WIDTH-1];
        mag_a = a_neg ? -dividend : dividend;
        mag_b = b_neg ? -divisor  : divisor;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The dividend bits are
    // consumed from the top of quo while quotient bits enter at the bottom.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        if (trial[WIDTH])
            return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
        else
            return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (kill) begin
            run_q <= 1'b0;
        end else if (start) begin
            {rem_q, quo_q} <= div_step('0, mag_a, mag_b);
            dvs_q          <= mag_b;
            cnt_q          <= CW'(WIDTH - 1);
            run_q          <= 1'b1;
            q_neg_q        <= a_neg ^ b_neg;
            r_neg_q        <= a_neg;
        end else if (run_q && cnt_q != '0) begin
            {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
            cnt_q          <= cnt_q - CW'(1);
        end
    end

    // Most-negative / -1 needs no special case: the magnitude quotient is
    // 2^(WIDTH-1), which is already the required bit pattern.
    assign quotient  = q_neg_q ? -quo_q : quo_q;
    assign remainder = r_neg_q ? -rem_q : rem_q;
    assign valid     = run_q && (cnt_q == '0);

endmodule

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
// Multiply/divide unit with architectural HI/LO registers. Multiplies finish
// MUL_LAT cycles after acceptance. When ALU_DIV_EN is defined an iterative
// divider (div_iter) is included; otherwise DIV/DIVU complete after one cycle
// without touching HI/LO.
// Configuration macro: ALU_DIV_EN (divider and FIX state present).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start, md_op   request and operation, sampled only when idle
//   a, b           operands (MTHI/MTLO write a)
//   cancel         flush the operation in flight; blocks a new start
//   busy           operation in flight
//   done           one-cycle completion pulse
//   hi, lo         architectural HI/LO registers
//   div_by_zero    pulses with done when a divide had a zero divisor
// -----------------------------------------------------------------------------
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    md_state_e        state_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic             mul_signed_q;
    logic [1:0]       mul_cnt_q;
    logic             busy_q, done_q, dbz_q;

    md_op_e op;
    logic   accept;

    assign op     = md_op_e'(md_op);
    assign accept = (state_q == ST_IDLE) && start && !cancel;

    // Inline multiplier: both operands extended to the full product width so
    // a single truncated multiply yields the signed or unsigned product.
    logic [2*WIDTH-1:0] ext_a, ext_b, mul_prod;

    always_comb begin
        ext_a    = mul_signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b    = mul_signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        mul_prod = ext_a * ext_b;
    end

`ifdef ALU_DIV_EN
    logic             div_start, div_valid, zero_div_q;
    logic [WIDTH-1:0] div_quo, div_rem;

    assign div_start = accept && (op == MD_DIV || op == MD_DIVU) && (b != '0);

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .kill      (cancel),
        .is_signed (op == MD_DIV),
        .dividend  (a),
        .divisor   (b),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );
`endif

    // NOTE: every register in this process, including the HI/LO datapath,
    // is reset, because reset must clear the architectural registers too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            mul_signed_q <= 1'b0;
            mul_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dbz_q        <= 1'b0;
`ifdef ALU_DIV_EN
            zero_div_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below
            // make done/div_by_zero single-cycle pulses.
            done_q <= 1'b0;
            dbz_q  <= 1'b0;

            if (state_q != ST_IDLE && cancel) begin
                // A flush wins over a completion due on the same edge.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            case (op)
                                MD_MULT, MD_MULTU: begin
                                    a_q          <= a;
                                    b_q          <= b;
                                    mul_signed_q <= (op == MD_MULT);
                                    mul_cnt_q    <= 2'(MUL_LAT - 1);
                                    state_q      <= ST_MUL;
                                    busy_q       <= 1'b1;
                                end
                                MD_DIV, MD_DIVU: begin
`ifdef ALU_DIV_EN
                                    zero_div_q <= (b == '0);
`endif
                                    state_q    <= ST_DIV;
                                    busy_q     <= 1'b1;
                                end
                                MD_MTHI: hi_q <= a;
                                MD_MTLO: lo_q <= a;
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        if (mul_cnt_q == 2'd0) begin
                            hi_q    <= mul_prod[2*WIDTH-1:WIDTH];
                            lo_q    <= mul_prod[WIDTH-1:0];
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            mul_cnt_q <= mul_cnt_q - 2'd1;
                        end
                    end
                    ST_DIV: begin
`ifdef ALU_DIV_EN
                        if (zero_div_q) begin
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (div_valid) begin
                            state_q <= ST_FIX;
                        end
`else
                        // No divider: complete at once, HI/LO untouched.
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`endif
                    end
                    ST_FIX: begin
`ifdef ALU_DIV_EN
                        hi_q   <= div_rem;
                        lo_q   <= div_quo;
                        done_q <= 1'b1;
`endif
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
